banked_memory_reader: RTL and testbench
=======================================

BANKED_MEMORY_READER -- requirements
Module: banked_memory_reader

Interface
REQ-001 Parameter DATA_W, default 16, memory word width in bits.
REQ-002 Parameter OFFSET_W, default 8, in-bank word offset width; memory address width = OFFSET_W+2.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 bank_sel  input  2  current bank from the memory bank selector register.
REQ-006 rd_req  input  1  read request; sampled only when rd_ready=1.
REQ-007 rd_offset  input  OFFSET_W  word offset within bank.
REQ-008 rd_ready  output  1  block idle, able to accept rd_req.
REQ-009 rd_valid  output  1  rd_data holds a completed read.
REQ-010 rd_data  output  DATA_W  read result.
REQ-011 rd_ack  input  1  consumer accepts rd_data; meaningful only while rd_valid=1.
REQ-012 mem_en  output  1  one-cycle read strobe to synchronous memory.
REQ-013 mem_addr  output  OFFSET_W+2  {bank, offset} to memory.
REQ-014 mem_data  input  DATA_W  memory read data, valid the cycle after the edge on which memory sees mem_en=1.
REQ-015 read_count  output  8  number of completed reads, modulo 256.

Function
REQ-016 FSM states: IDLE, ISSUE, CAPTURE, HOLD; encoding free, no other reachable states.
REQ-017 rd_ready SHALL be 1 exactly when state=IDLE (decoded from state, no extra register).
REQ-018 IDLE, rd_req=1 at edge: register mem_addr <= {bank_sel, rd_offset}, mem_en <= 1, state <= ISSUE.
REQ-019 IDLE, rd_req=0: hold; mem_en stays 0, mem_addr holds its last value.
REQ-020 ISSUE: next edge mem_en <= 0, state <= CAPTURE; mem_en SHALL be high for exactly one cycle per read.
REQ-021 CAPTURE: next edge rd_data <= mem_data, rd_valid <= 1, read_count <= read_count+1, state <= HOLD.
REQ-022 Latency: rd_valid rises 3 edges after the accepting edge (accept edge E0, rd_valid=1 after E2).
REQ-023 HOLD: rd_valid and rd_data held stable until an edge with rd_ack=1; that edge clears rd_valid, state <= IDLE.
REQ-024 rd_ack while not in HOLD SHALL be ignored.
REQ-025 Bank and offset latched at accept; bank_sel/rd_offset changes after accept SHALL NOT affect the in-flight read.
REQ-026 rd_req while not IDLE SHALL be ignored (no queuing); the requester must re-present after rd_ready.
REQ-027 Back-to-back: after the ack edge the block is IDLE and SHALL accept a request on the following edge.
REQ-028 read_count wraps 255 -> 0 without flag or stall.
REQ-029 rd_data retains the last captured value after ack until the next CAPTURE.

Reset
REQ-030 reset=1 at an edge SHALL force state=IDLE, mem_en=0, mem_addr=0, rd_valid=0, rd_data=0, read_count=0, overriding all other inputs.
REQ-031 After reset rd_ready=1.
REQ-032 Reset mid-read (ISSUE/CAPTURE/HOLD) SHALL abandon the read: no rd_valid, no count increment, mem_en deasserted at that edge.
REQ-033 reset held high for multiple cycles SHALL keep all outputs at reset values and ignore rd_req.

Verification
REQ-034 Reset then idle: reset 2 cycles, rd_req=0 for 3 -> rd_ready=1, rd_valid=0, mem_en=0, mem_addr=0, read_count=0.
REQ-035 Single read: bank_sel=2'b10, rd_offset=8'h05, rd_req 1 cycle, model memory returns 16'hBEEF -> mem_addr=10'h205, mem_en high one cycle, rd_valid after 3rd edge, rd_data=16'hBEEF, read_count=1; rd_ack -> rd_valid=0, rd_ready=1.
REQ-036 Bank change in flight: accept with bank_sel=2'b01, offset 8'h10, switch bank_sel to 2'b11 next cycle -> mem_addr stays 10'h110, data from that address.
REQ-037 Delayed ack / ignored request: hold rd_ack=0 for 5 cycles in HOLD while pulsing rd_req -> rd_valid and rd_data stable, mem_en stays 0, read_count unchanged.
REQ-038 Reset mid-read: reset asserted in CAPTURE -> no rd_valid, read_count=0, rd_ready=1 next cycle.
REQ-039 Counter wrap: 256 completed reads from reset -> read_count=0; 257th -> 1.

Source files
------------

// File: rtl/banked_memory_reader_if.sv
// Read-port and memory-port bundle for banked_memory_reader.
// The reader takes the slave view; the requester/memory side takes the master view.
interface banked_memory_reader_if #(
    parameter int DATA_W   = 16,
    parameter int OFFSET_W = 8
);
    logic [1:0]          bank_sel;
    logic                rd_req;
    logic [OFFSET_W-1:0] rd_offset;
    logic                rd_ready;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_ack;
    logic                mem_en;
    logic [OFFSET_W+1:0] mem_addr;
    logic [DATA_W-1:0]   mem_data;
    logic [7:0]          read_count;

    modport slave (
        input  bank_sel, rd_req, rd_offset, rd_ack, mem_data,
        output rd_ready, rd_valid, rd_data, mem_en, mem_addr, read_count
    );

    modport master (
        output bank_sel, rd_req, rd_offset, rd_ack, mem_data,
        input  rd_ready, rd_valid, rd_data, mem_en, mem_addr, read_count
    );
endinterface

// File: rtl/banked_memory_reader.sv
// Single-outstanding reader for a banked synchronous memory.
// Each read runs IDLE -> ISSUE -> CAPTURE -> HOLD and then waits for the consumer's ack.
module banked_memory_reader #(
    parameter int DATA_W   = 16,
    parameter int OFFSET_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    banked_memory_reader_if.slave  bus
);
    localparam int ADDR_W = OFFSET_W + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    state_e            state_q,      state_d;
    logic              mem_en_q,     mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              rd_valid_q,   rd_valid_d;
    logic [DATA_W-1:0] rd_data_q,    rd_data_d;
    logic [7:0]        read_count_q, read_count_d;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        mem_en_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        read_count_d = read_count_q;

        case (state_q)
            IDLE: begin
                if (bus.rd_req) begin
                    // Bank and offset are frozen here; later input changes cannot reach the read.
                    mem_addr_d = {bus.bank_sel, bus.rd_offset};
                    mem_en_d   = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rd_data_d    = bus.mem_data;
                rd_valid_d   = 1'b1;
                read_count_d = read_count_q + 8'd1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (bus.rd_ack) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments only, so every register samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            read_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            read_count_q <= read_count_d;
        end
    end

    assign bus.rd_ready   = (state_q == IDLE);
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.read_count = read_count_q;
endmodule

// File: tb/tb_banked_memory_reader.sv
// Directed bench for banked_memory_reader with a synchronous memory model
// and a queue of expected read data.
module tb_banked_memory_reader;
    localparam int DATA_W   = 16;
    localparam int OFFSET_W = 8;

    logic clk;
    logic reset;

    banked_memory_reader_if #(.DATA_W(DATA_W), .OFFSET_W(OFFSET_W)) bus ();

    banked_memory_reader #(.DATA_W(DATA_W), .OFFSET_W(OFFSET_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem_model [1024];
    logic [DATA_W-1:0] sb [$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_count = 0;

    // Memory returns data the cycle after it sees mem_en high at an edge.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_data <= mem_model[bus.mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One complete read; optional input scrambling, stray ack/req during the
    // pipeline, and a number of HOLD cycles before the ack is given.
    task automatic do_read(input logic [1:0] bank, input logic [7:0] off,
                           input bit detailed, input bit scramble, input int hold_cycles);
        logic [9:0]        addr;
        logic [DATA_W-1:0] exp_data;
        int                lat;
        addr          = {bank, off};
        bus.bank_sel  = bank;
        bus.rd_offset = off;
        bus.rd_req    = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        sb.push_back(mem_model[addr]);
        if (scramble) begin
            bus.bank_sel  = ~bank;
            bus.rd_offset = ~off;
            bus.rd_ack    = 1'b1;
            bus.rd_req    = 1'b1;
        end
        if (detailed) begin
            check("accept_mem_en", 32'(bus.mem_en), 32'd1);
            check("accept_mem_addr", 32'(bus.mem_addr), 32'(addr));
            check("accept_rd_ready", 32'(bus.rd_ready), 32'd0);
        end
        lat = 1;
        while (!bus.rd_valid && lat < 8) begin
            tick();
            lat++;
            if (detailed && !bus.rd_valid) begin
                check("issue_mem_en_pulse", 32'(bus.mem_en), 32'd0);
                check("inflight_mem_addr", 32'(bus.mem_addr), 32'(addr));
            end
        end
        bus.rd_ack = 1'b0;
        bus.rd_req = 1'b0;
        check("latency_edges", 32'(lat), 32'd3);
        exp_data = sb.pop_front();
        exp_count++;
        check("rd_data", 32'(bus.rd_data), 32'(exp_data));
        check("read_count", 32'(bus.read_count), 32'(exp_count % 256));
        for (int i = 0; i < hold_cycles; i++) begin
            bus.rd_req   = ~bus.rd_req;
            bus.bank_sel = bus.bank_sel + 2'd1;
            tick();
            check("hold_rd_valid", 32'(bus.rd_valid), 32'd1);
            check("hold_rd_data", 32'(bus.rd_data), 32'(exp_data));
            check("hold_mem_en", 32'(bus.mem_en), 32'd0);
            check("hold_read_count", 32'(bus.read_count), 32'(exp_count % 256));
        end
        bus.rd_req = 1'b0;
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        if (detailed) begin
            check("ack_rd_valid", 32'(bus.rd_valid), 32'd0);
            check("ack_rd_ready", 32'(bus.rd_ready), 32'd1);
            check("ack_rd_data_kept", 32'(bus.rd_data), 32'(exp_data));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 16'((i * 40503) ^ 23130);
        mem_model[10'h205] = 16'hBEEF;

        bus.bank_sel  = 2'b00;
        bus.rd_offset = '0;
        bus.rd_req    = 1'b1;
        bus.rd_ack    = 1'b0;
        reset         = 1'b1;

        // Reset held with a request present: request must be ignored.
        tick();
        tick();
        check("rst_hold_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_hold_rd_ready", 32'(bus.rd_ready), 32'd1);
        reset      = 1'b0;
        bus.rd_req = 1'b0;
        repeat (3) tick();
        check("idle_rd_ready", 32'(bus.rd_ready), 32'd1);
        check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("idle_mem_en", 32'(bus.mem_en), 32'd0);
        check("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("idle_read_count", 32'(bus.read_count), 32'd0);
        check("idle_rd_data", 32'(bus.rd_data), 32'd0);

        // Single read of 0x205.
        do_read(2'b10, 8'h05, 1'b1, 1'b0, 0);
        check("beef_rd_data", 32'(bus.rd_data), 32'h0000_BEEF);

        // Bank/offset change in flight plus stray ack/req before HOLD.
        do_read(2'b01, 8'h10, 1'b1, 1'b1, 0);

        // Delayed ack with requests pulsed during HOLD.
        do_read(2'b11, 8'hA7, 1'b1, 1'b0, 5);

        // Back-to-back reads immediately after the ack edge.
        do_read(2'b00, 8'hFF, 1'b1, 1'b0, 0);
        do_read(2'b10, 8'h00, 1'b1, 1'b0, 0);

        // Reset asserted while in CAPTURE abandons the read.
        bus.bank_sel  = 2'b01;
        bus.rd_offset = 8'h33;
        bus.rd_req    = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        exp_count = 0;
        check("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("midrst_mem_en", 32'(bus.mem_en), 32'd0);
        check("midrst_read_count", 32'(bus.read_count), 32'd0);
        check("midrst_rd_ready", 32'(bus.rd_ready), 32'd1);
        tick();
        check("postrst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("postrst_rd_ready", 32'(bus.rd_ready), 32'd1);

        // Counter wrap: 255 reads, then the 256th and 257th.
        for (int i = 0; i < 255; i++) begin
            do_read(2'(i), 8'(i * 7), 1'b0, 1'b0, 0);
        end
        check("count_255", 32'(bus.read_count), 32'd255);
        do_read(2'b01, 8'h42, 1'b1, 1'b0, 0);
        check("count_wrap_0", 32'(bus.read_count), 32'd0);
        do_read(2'b10, 8'h43, 1'b1, 1'b0, 0);
        check("count_wrap_1", 32'(bus.read_count), 32'd1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
